fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Front-end sequencing controller for the BTB-predicted fetch stage. It compares each EX-resolved branch or jump against the prediction carried down the pipe, and drives:
- the fetch redirect (modify_pc_ex / update_pc_ex),
- the BTB update strobe,
- PC enable and IF/ID + ID/EX flushes.

It also owns the post-reset boot hold, mispredict recovery, halt, and branch/mispredict performance counters. It sits between the hazard unit, the EX stage and the fetch stage.

Parameters:
BOOT_CYCLES, 4, cycles PC held and pipe flushed after reset release (>=1)
RECOVER_CYCLES, 1, cycles after a redirect during which EX resolutions are ignored and IF/ID flush held (>=1)
CNT_W, 16, width of saturating performance counters

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
hazard_stall  in  1  load-use stall from hazard unit
halt_req  in  1  request to stop fetch permanently
ex_valid  in  1  EX holds a non-bubble instruction
ex_is_branch  in  1  EX instr is conditional branch
ex_is_jump  in  1  EX instr is jal/jalr
ex_actual_taken  in  1  resolved direction (forced 1 for jumps)
ex_pred_taken  in  1  prediction carried from IF
ex_pred_target  in  32  predicted target carried from IF
ex_actual_target  in  32  resolved target
ex_pc  in  32  PC of EX instruction
pc_en  out  1  fetch PC register enable
modify_pc_ex  out  1  redirect fetch this cycle
update_pc_ex  out  32  redirect target
update_btb_ex  out  1  BTB write strobe
ex_branch_taken  out  1  direction written to BTB
flush_ifid  out  1  clear IF/ID
flush_idex  out  1  clear ID/EX
halted  out  1  controller in HALT
branch_cnt  out  CNT_W  resolved branches+jumps
mispredict_cnt  out  CNT_W  redirects issued

Behaviour:
- FSM states: BOOT, RUN, RECOVER, HALT. rst=0 at a clk edge -> BOOT, boot/recover counter=0, both perf counters=0. This applies mid-operation too; no partial state survives.
- Outputs are combinational from state + EX inputs. Fetch uses modify_pc_ex in the same cycle, so redirect latency is 0 cycles.
- BOOT:
  - Outputs: pc_en=0, flush_ifid=flush_idex=1, modify_pc_ex=0, update_btb_ex=0, halted=0.
  - After BOOT_CYCLES cycles -> RUN.
- RUN:
  - res = ex_valid & (ex_is_branch | ex_is_jump).
  - mis = res & ((ex_actual_taken != ex_pred_taken) | (ex_actual_taken & ex_pred_taken & ex_actual_target != ex_pred_target)).
  - update_btb_ex = res; ex_branch_taken = ex_actual_taken.
  - mis=1:
    - modify_pc_ex=1; update_pc_ex = ex_actual_taken ? ex_actual_target : ex_pc+4 (32-bit wrap).
    - flush_ifid=flush_idex=1; pc_en=1 (redirect overrides hazard_stall).
    - Next state RECOVER.
  - mis=0:
    - pc_en = ~hazard_stall; flush_idex = hazard_stall (bubble insert); flush_ifid=0.
  - halt_req & ~mis -> HALT next cycle. halt_req & mis -> redirect completes first: RECOVER, then HALT on exit if halt_req still high.
- RECOVER:
  - EX inputs ignored: modify_pc_ex=0, update_btb_ex=0.
  - flush_ifid=1, flush_idex=1, pc_en=1.
  - After RECOVER_CYCLES cycles -> RUN, or HALT if halt_req.
- HALT:
  - pc_en=0, flush_ifid=flush_idex=1, halted=1.
  - Exit only via reset.
- update_pc_ex = 0 whenever modify_pc_ex=0.
- Counters:
  - branch_cnt += res in RUN only.
  - mispredict_cnt += mis.
  - Both saturate at all-ones; no wrap.

Decomposition:
- Shared package holds:
  - the state enum encoding (BOOT=2'd0, RUN=2'd1, RECOVER=2'd2, HALT=2'd3);
  - the PC_INC=32'd4 constant.
- One sub-module, sat_counter (CNT_W, inc, clear), instantiated twice.

Test Plan:
- Reset low 3 cycles, release, BOOT_CYCLES=4 -> pc_en=0 and both flushes=1 for cycles 0..3 after release; pc_en=1 on cycle 4; counters=0.
- RUN, ex_valid=1, ex_is_branch=1, pred_taken=0, actual_taken=1, target=0x0000_0100 -> same cycle modify_pc_ex=1, update_pc_ex=0x100, update_btb_ex=1, both flushes=1; next cycle RECOVER with modify_pc_ex=0 despite a valid EX branch; mispredict_cnt=1, branch_cnt=1.
- Predicted taken to 0x200, actual taken to 0x204, ex_pc=0x80 -> redirect to 0x204. Predicted taken, actual not-taken, ex_pc=0xFFFF_FFFC -> redirect to 0x0000_0000 (wrap).
- Correct prediction with hazard_stall=1 -> pc_en=0, flush_idex=1, modify_pc_ex=0, update_btb_ex=1. Mispredict with hazard_stall=1 -> pc_en=1.
- halt_req with a simultaneous mispredict -> redirect issued, RECOVER for 1 cycle, then halted=1, pc_en=0 until rst=0.
- CNT_W=4, 20 consecutive resolved branches -> branch_cnt holds 4'hF. rst=0 in RECOVER -> BOOT and counters cleared.

Source files
------------

// File: rtl/fetch_redirect_ctrl_pkg.sv
// Shared definitions for the fetch redirect controller: FSM state encoding
// and the sequential-fetch PC increment.
package fetch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT    = 2'd0,
    ST_RUN     = 2'd1,
    ST_RECOVER = 2'd2,
    ST_HALT    = 2'd3
  } state_e;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/fetch_redirect_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch-stage sequencing: resolves EX branches against the carried prediction,
// redirects fetch with zero latency, and owns boot hold, recovery and halt.
module fetch_redirect_ctrl
  import fetch_redirect_ctrl_pkg::*;
#(
  parameter int BOOT_CYCLES    = 4,
  parameter int RECOVER_CYCLES = 1,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard_stall,
  input  logic             halt_req,
  input  logic             ex_valid,
  input  logic             ex_is_branch,
  input  logic             ex_is_jump,
  input  logic             ex_actual_taken,
  input  logic             ex_pred_taken,
  input  logic [31:0]      ex_pred_target,
  input  logic [31:0]      ex_actual_target,
  input  logic [31:0]      ex_pc,
  output logic             pc_en,
  output logic             modify_pc_ex,
  output logic [31:0]      update_pc_ex,
  output logic             update_btb_ex,
  output logic             ex_branch_taken,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int MAX_CYC = (BOOT_CYCLES > RECOVER_CYCLES) ? BOOT_CYCLES : RECOVER_CYCLES;
  localparam int CTR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CTR_W-1:0] BOOT_LAST = CTR_W'(BOOT_CYCLES - 1);
  localparam logic [CTR_W-1:0] REC_LAST  = CTR_W'(RECOVER_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CTR_W-1:0] cyc_q, cyc_d;

  logic res;
  logic mis;
  logic in_run;
  logic cnt_clear;

  assign res = ex_valid & (ex_is_branch | ex_is_jump);
  // A taken/taken pair still mispredicts when the carried target was stale.
  assign mis = res & ((ex_actual_taken != ex_pred_taken) |
                      (ex_actual_taken & ex_pred_taken & (ex_actual_target != ex_pred_target)));
  assign in_run    = (state_q == ST_RUN);
  assign cnt_clear = ~rst;

  always_comb begin
    state_d         = state_q;
    cyc_d           = cyc_q;
    pc_en           = 1'b0;
    modify_pc_ex    = 1'b0;
    update_pc_ex    = '0;
    update_btb_ex   = 1'b0;
    ex_branch_taken = 1'b0;
    flush_ifid      = 1'b1;
    flush_idex      = 1'b1;
    halted          = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        if (cyc_q == BOOT_LAST) begin
          state_d = ST_RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CTR_W'(1);
        end
      end
      ST_RUN: begin
        update_btb_ex   = res;
        ex_branch_taken = ex_actual_taken;
        if (mis) begin
          // Redirect wins over the load-use stall; a pending halt waits for recovery.
          modify_pc_ex = 1'b1;
          update_pc_ex = ex_actual_taken ? ex_actual_target : (ex_pc + PC_INC);
          pc_en        = 1'b1;
          state_d      = ST_RECOVER;
          cyc_d        = '0;
        end else begin
          pc_en      = ~hazard_stall;
          flush_ifid = 1'b0;
          flush_idex = hazard_stall;
          if (halt_req) begin
            state_d = ST_HALT;
          end
        end
      end
      ST_RECOVER: begin
        pc_en = 1'b1;
        if (cyc_q == REC_LAST) begin
          state_d = halt_req ? ST_HALT : ST_RUN;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CTR_W'(1);
        end
      end
      ST_HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = ST_BOOT;
        cyc_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_BOOT;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (in_run & res),
    .count (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispredict_cnt (
    .clk   (clk),
    .clear (cnt_clear),
    .inc   (in_run & mis),
    .count (mispredict_cnt)
  );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench: driver predicts each cycle's outputs from a behavioural model,
// a negedge monitor pops and compares against the DUT.
module tb_fetch_redirect_ctrl;

  localparam int BOOT_N = 4;
  localparam int REC_N  = 1;
  localparam int CW     = 4;
  localparam int CMAX   = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, hazard_stall, halt_req, ex_valid, ex_is_branch, ex_is_jump;
  logic        ex_actual_taken, ex_pred_taken;
  logic [31:0] ex_pred_target, ex_actual_target, ex_pc;
  logic        pc_en, modify_pc_ex, update_btb_ex, ex_branch_taken;
  logic        flush_ifid, flush_idex, halted;
  logic [31:0] update_pc_ex;
  logic [CW-1:0] branch_cnt, mispredict_cnt;

  fetch_redirect_ctrl #(
    .BOOT_CYCLES(BOOT_N), .RECOVER_CYCLES(REC_N), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .hazard_stall(hazard_stall), .halt_req(halt_req),
    .ex_valid(ex_valid), .ex_is_branch(ex_is_branch), .ex_is_jump(ex_is_jump),
    .ex_actual_taken(ex_actual_taken), .ex_pred_taken(ex_pred_taken),
    .ex_pred_target(ex_pred_target), .ex_actual_target(ex_actual_target),
    .ex_pc(ex_pc), .pc_en(pc_en), .modify_pc_ex(modify_pc_ex),
    .update_pc_ex(update_pc_ex), .update_btb_ex(update_btb_ex),
    .ex_branch_taken(ex_branch_taken), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .halted(halted),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt)
  );

  typedef struct {
    int          cyc;
    logic        pc_en, modify, upd_btb, taken, f_ifid, f_idex, halted;
    logic [31:0] upd_pc;
    int          bcnt, mcnt;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;

  // Reference model: phase name plus cycles spent in the current timed phase.
  string m_phase = "boot";
  int    m_spent = 0;
  int    m_bcnt  = 0;
  int    m_mcnt  = 0;

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=0x%08h required=0x%08h", name, cyc, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("pc_en",      e.cyc, 32'(pc_en),           32'(e.pc_en));
      chk("modify_pc",  e.cyc, 32'(modify_pc_ex),    32'(e.modify));
      chk("update_pc",  e.cyc, update_pc_ex,         e.upd_pc);
      chk("update_btb", e.cyc, 32'(update_btb_ex),   32'(e.upd_btb));
      if (e.upd_btb) chk("br_taken", e.cyc, 32'(ex_branch_taken), 32'(e.taken));
      chk("flush_ifid", e.cyc, 32'(flush_ifid),      32'(e.f_ifid));
      chk("flush_idex", e.cyc, 32'(flush_idex),      32'(e.f_idex));
      chk("halted",     e.cyc, 32'(halted),          32'(e.halted));
      chk("branch_cnt", e.cyc, 32'(branch_cnt),      32'(e.bcnt));
      chk("mispr_cnt",  e.cyc, 32'(mispredict_cnt),  32'(e.mcnt));
      $display("cyc=%0d pc_en=%0b mod=%0b upc=%08h btb=%0b fi=%0b fx=%0b h=%0b bc=%0d mc=%0d",
               e.cyc, pc_en, modify_pc_ex, update_pc_ex, update_btb_ex,
               flush_ifid, flush_idex, halted, branch_cnt, mispredict_cnt);
    end
  end

  task automatic drive(input bit r, input bit st, input bit hr, input bit v, input bit br,
                       input bit jp, input bit at, input bit pt, input logic [31:0] ptgt,
                       input logic [31:0] atgt, input logic [31:0] pc);
    exp_t e;
    bit res, wrong;
    string nxt;
    rst = r; hazard_stall = st; halt_req = hr; ex_valid = v; ex_is_branch = br;
    ex_is_jump = jp; ex_actual_taken = at; ex_pred_taken = pt;
    ex_pred_target = ptgt; ex_actual_target = atgt; ex_pc = pc;

    res   = v && (br || jp);
    wrong = res && ((at != pt) || (at && pt && (atgt != ptgt)));
    e.cyc = cycle; e.pc_en = 0; e.modify = 0; e.upd_pc = 0; e.upd_btb = 0; e.taken = 0;
    e.f_ifid = 1; e.f_idex = 1; e.halted = 0; e.bcnt = m_bcnt; e.mcnt = m_mcnt;
    nxt = m_phase;

    if (m_phase == "boot") begin
      m_spent++;
      if (m_spent == BOOT_N) begin nxt = "run"; m_spent = 0; end
    end else if (m_phase == "run") begin
      e.upd_btb = res; e.taken = at;
      if (res) m_bcnt = (m_bcnt < CMAX) ? m_bcnt + 1 : CMAX;
      if (wrong) begin
        e.modify = 1; e.pc_en = 1;
        e.upd_pc = at ? atgt : 32'(64'(pc) + 64'd4);
        m_mcnt = (m_mcnt < CMAX) ? m_mcnt + 1 : CMAX;
        nxt = "recover"; m_spent = 0;
      end else begin
        e.pc_en = !st; e.f_ifid = 0; e.f_idex = st;
        if (hr) nxt = "halt";
      end
    end else if (m_phase == "recover") begin
      e.pc_en = 1;
      m_spent++;
      if (m_spent == REC_N) begin nxt = hr ? "halt" : "run"; m_spent = 0; end
    end else begin
      e.halted = 1;
    end
    exp_q.push_back(e);

    if (!r) begin
      nxt = "boot"; m_spent = 0; m_bcnt = 0; m_mcnt = 0;
    end
    m_phase = nxt;
    @(posedge clk); #1;
    cycle++;
  endtask

  task automatic idle(input bit r, input bit hr);
    drive(r, 0, hr, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic [31:0] tgts [4];
    tgts[0] = 32'h100; tgts[1] = 32'h104; tgts[2] = 32'h200; tgts[3] = 32'h204;
    rst = 0; hazard_stall = 0; halt_req = 0; ex_valid = 0; ex_is_branch = 0;
    ex_is_jump = 0; ex_actual_taken = 0; ex_pred_taken = 0;
    ex_pred_target = 0; ex_actual_target = 0; ex_pc = 0;
    @(posedge clk); #1;

    repeat (3) idle(0, 0);
    repeat (BOOT_N + 1) idle(1, 0);
    drive(1, 0, 0, 1, 1, 0, 1, 0, 32'h0, 32'h100, 32'h40);          // not-taken predicted, taken
    drive(1, 0, 0, 1, 1, 0, 1, 0, 32'h0, 32'h100, 32'h40);          // ignored in recovery
    drive(1, 0, 0, 1, 1, 0, 1, 1, 32'h200, 32'h204, 32'h80);        // stale target
    idle(1, 0);
    drive(1, 0, 0, 1, 1, 0, 0, 1, 32'h200, 32'h0, 32'hFFFF_FFFC);   // fall-through wraps
    idle(1, 0);
    drive(1, 1, 0, 1, 1, 0, 1, 1, 32'h300, 32'h300, 32'h90);        // correct under stall
    drive(1, 1, 0, 1, 0, 1, 1, 0, 32'h0, 32'h500, 32'h94);          // mispredict under stall
    idle(1, 0);
    drive(1, 0, 1, 1, 1, 0, 1, 0, 32'h0, 32'h600, 32'hA0);          // halt with mispredict
    idle(1, 1);
    repeat (3) idle(1, 0);
    idle(0, 0);
    repeat (BOOT_N) idle(1, 0);
    repeat (20) drive(1, 0, 0, 1, 1, 0, 0, 0, 32'h0, 32'h0, 32'h10);
    drive(1, 0, 0, 1, 0, 1, 1, 0, 32'h0, 32'h700, 32'h20);
    idle(0, 0);                                                     // reset while recovering
    repeat (BOOT_N + 2) idle(1, 0);

    for (int i = 0; i < 2500; i++) begin
      bit jp, at;
      logic [31:0] pc;
      jp = ($urandom_range(0, 3) == 0);
      at = jp ? 1'b1 : 1'($urandom_range(0, 1));
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      drive($urandom_range(0, 59) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 79) == 0,
            $urandom_range(0, 3) != 0, !jp, jp, at, 1'($urandom_range(0, 1)),
            tgts[$urandom_range(0, 3)], tgts[$urandom_range(0, 3)], pc);
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
